// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store controller between the EX/MEM pipeline register and the
//   word-wide Datamemory block. Byte/halfword/word requests at byte addresses
//   are turned into word accesses. Sub-word stores use read-modify-write, and
//   loads are sign- or zero-extended. While an access is in progress the
//   pipeline is stalled through req_ready.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   req_valid/ready request handshake (ready high only when idle)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    zero-extend loads
//   req_addr        byte address (bits above the memory size are ignored)
//   req_wdata       right-aligned store data
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data; 0 for stores and errors
//   misaligned      error flag, valid with resp_valid
//   MemRead/MemWrite/a/wd/rd  Datamemory interface (rd is combinational)
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  misaligned,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int AW = DM_ADDRESS + 2;  // byte-address bits that reach memory

  logic [2:0]        state_q,  state_d;
  logic [AW-1:0]     addr_q,   addr_d;
  logic [1:0]        size_q,   size_d;
  logic              uns_q,    uns_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] buf_q,    buf_d;    // word to be written
  logic [DATA_W-1:0] rdata_q,  rdata_d;  // response data
  logic              mis_q,    mis_d;

  // Upper address bits wrap away; they are intentionally not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW];

  // Request-time alignment / size check.
  logic req_bad;
  assign req_bad = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

  // Lane extraction and extension of the word currently on rd.
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] st_merge;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    ld_byte  = rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = addr_q[1] ? rd[31:16] : rd[15:0];
    ld_ext   = rd;
    st_merge = rd;
    case (size_q)
      SZ_BYTE: begin
        ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[AW-1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
          mis_d   = 1'b0;
          if (req_bad) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD;
          end else if (req_size == SZ_WORD) begin
            buf_d   = req_wdata;
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        buf_d   = st_merge;
        state_d = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // All outputs decode registered state only.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign misaligned = resp_valid & mis_q;
  assign MemRead    = (state_q == RD) || (state_q == RMW_RD);
  assign MemWrite   = (state_q == WR);
  assign a          = addr_q[AW-1:2];
  assign wd         = MemWrite ? buf_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  localparam int DM = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          misaligned;
  logic          MemRead;
  logic          MemWrite;
  logic [DM-1:0] a;
  logic [31:0]   wd;
  logic [31:0]   rd;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DM_ADDRESS(DM), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misaligned(misaligned), .MemRead(MemRead), .MemWrite(MemWrite),
    .a(a), .wd(wd), .rd(rd)
  );

  // Datamemory model: combinational read, write on rising edge.
  logic [31:0] mem [0:(1<<DM)-1];
  assign rd = mem[a];
  always @(posedge clk) if (MemWrite) mem[a] <= wd;

  int n_checks = 0;
  int n_pass   = 0;
  int both_hi  = 0;

  always @(negedge clk) if (MemRead && MemWrite) both_hi++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [DM-1:0] exp_a;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] ad, input logic [31:0] wdat,
                              input logic [31:0] er, input logic em, input int el,
                              input int erd, input int ewr, input logic [DM-1:0] ea,
                              input logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.we = we; v.sz = sz; v.uns = uns; v.addr = ad; v.wdata = wdat;
    v.exp_rdata = er; v.exp_mis = em; v.exp_lat = el; v.exp_rd = erd;
    v.exp_wr = ewr; v.exp_a = ea; v.exp_wd = ewd;
    return v;
  endfunction

  // Issue one request from IDLE and observe it to completion.
  task automatic run_vec(input vec_t v);
    int lat = 0, rd_cnt = 0, wr_cnt = 0, rdy_low = 0;
    logic [DM-1:0] rec_a = '0;
    logic [31:0] rec_wd = '0, rec_rdata = '0;
    logic rec_mis = 1'b0;
    logic done = 1'b0;
    @(negedge clk);
    check({v.name, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (!req_ready) rdy_low++;
      if (MemRead) begin rd_cnt++; rec_a = a; end
      if (MemWrite) begin wr_cnt++; rec_a = a; rec_wd = wd; end
      if (resp_valid) begin
        done = 1'b1; rec_rdata = resp_rdata; rec_mis = misaligned;
      end
    end
    check({v.name, ".latency"},   32'(lat),     32'(v.exp_lat));
    check({v.name, ".ready_low"}, 32'(rdy_low), 32'(v.exp_lat));
    check({v.name, ".rdata"},     rec_rdata,    v.exp_rdata);
    check({v.name, ".misaligned"},32'(rec_mis), 32'(v.exp_mis));
    check({v.name, ".memread_n"}, 32'(rd_cnt),  32'(v.exp_rd));
    check({v.name, ".memwrite_n"},32'(wr_cnt),  32'(v.exp_wr));
    check({v.name, ".addr"},      32'(rec_a),   32'(v.exp_a));
    check({v.name, ".wd"},        rec_wd,       v.exp_wd);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] exp;
  } b2b_t;

  b2b_t seq [4];

  initial begin
    int idx, rcnt, mw_seen, rv_seen;
    for (int i = 0; i < (1<<DM); i++) mem[i] = '0;
    mem[5] = 32'h0070_0093;

    //             name     we  sz     uns addr   wdata         rdata        mis lat rd wr a  wd
    vecs[0]  = mk("lb20",   0, 2'b00, 0, 20,    0,            32'hFFFFFF93, 0, 2, 1, 0, 5, 0);
    vecs[1]  = mk("lbu20",  0, 2'b00, 1, 20,    0,            32'h00000093, 0, 2, 1, 0, 5, 0);
    vecs[2]  = mk("lh22",   0, 2'b01, 0, 22,    0,            32'h00000070, 0, 2, 1, 0, 5, 0);
    vecs[3]  = mk("lw20",   0, 2'b10, 0, 20,    0,            32'h00700093, 0, 2, 1, 0, 5, 0);
    vecs[4]  = mk("lb22",   0, 2'b00, 0, 22,    0,            32'h00000070, 0, 2, 1, 0, 5, 0);
    vecs[5]  = mk("lhu20",  0, 2'b01, 1, 20,    0,            32'h00000093, 0, 2, 1, 0, 5, 0);
    vecs[6]  = mk("sw12",   1, 2'b10, 0, 12,    32'h12345678, 0,            0, 2, 0, 1, 3, 32'h12345678);
    vecs[7]  = mk("sb13",   1, 2'b00, 0, 13,    32'h000000AB, 0,            0, 3, 1, 1, 3, 32'h1234AB78);
    vecs[8]  = mk("sh14",   1, 2'b01, 0, 14,    32'h0000BEEF, 0,            0, 3, 1, 1, 3, 32'hBEEFAB78);
    vecs[9]  = mk("lh14",   0, 2'b01, 0, 14,    0,            32'hFFFFBEEF, 0, 2, 1, 0, 3, 0);
    vecs[10] = mk("lhu14",  0, 2'b01, 1, 14,    0,            32'h0000BEEF, 0, 2, 1, 0, 3, 0);
    vecs[11] = mk("lb15",   0, 2'b00, 0, 15,    0,            32'hFFFFFFBE, 0, 2, 1, 0, 3, 0);
    vecs[12] = mk("lw6",    0, 2'b10, 0, 6,     0,            0,            1, 1, 0, 0, 0, 0);
    vecs[13] = mk("sh9",    1, 2'b01, 0, 9,     32'h0000FFFF, 0,            1, 1, 0, 0, 0, 0);
    vecs[14] = mk("size11", 0, 2'b11, 0, 0,     0,            0,            1, 1, 0, 0, 0, 0);
    vecs[15] = mk("lw2068", 0, 2'b10, 0, 2068,  0,            32'h00700093, 0, 2, 1, 0, 5, 0);
    vecs[16] = mk("sb2",    1, 2'b00, 0, 2,     32'hFFFFFF5A, 0,            0, 3, 1, 1, 0, 32'h005A0000);
    vecs[17] = mk("lb2",    0, 2'b00, 0, 2,     0,            32'h0000005A, 0, 2, 1, 0, 0, 0);
    vecs[18] = mk("lh2",    0, 2'b01, 0, 2,     0,            32'h0000005A, 0, 2, 1, 0, 0, 0);
    vecs[19] = mk("lbu13",  0, 2'b00, 1, 13,    0,            32'h000000AB, 0, 2, 1, 0, 3, 0);

    seq[0] = '{2'b10, 1'b0, 32'd20,   32'h00700093};
    seq[1] = '{2'b10, 1'b0, 32'd2068, 32'h00700093};
    seq[2] = '{2'b00, 1'b1, 32'd13,   32'h000000AB};
    seq[3] = '{2'b01, 1'b0, 32'd12,   32'hFFFFAB78};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.ready",      32'(req_ready),  32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.rdata",      resp_rdata,      32'd0);
    check("rst.misaligned", 32'(misaligned), 32'd0);
    check("rst.memread",    32'(MemRead),    32'd0);
    check("rst.memwrite",   32'(MemWrite),   32'd0);
    check("rst.a",          32'(a),          32'd0);
    check("rst.wd",         wd,              32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);
    check("mem.word3", mem[3], 32'hBEEFAB78);
    check("mem.word0", mem[0], 32'h005A0000);

    // Back-to-back: req_valid held high, next request presented after each accept.
    idx = 0; rcnt = 0;
    @(negedge clk);
    req_we = 1'b0; req_size = seq[0].sz; req_unsigned = seq[0].uns;
    req_addr = seq[0].addr; req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && rcnt < 4; cyc++) begin
      logic acc;
      acc = req_ready && req_valid;
      if (resp_valid) begin
        check($sformatf("b2b[%0d].rdata", rcnt), resp_rdata, seq[rcnt].exp);
        rcnt++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_size = seq[idx].sz; req_unsigned = seq[idx].uns; req_addr = seq[idx].addr;
        end else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b.responses", 32'(rcnt), 32'd4);
    check("b2b.accepts",   32'(idx),  32'd4);

    // Reset while a sub-word store sits in RMW_RD.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd13; req_wdata = 32'h000000CD; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid.in_rmw_rd", 32'(MemRead), 32'd1);
    reset = 1'b1;
    mw_seen = 0; rv_seen = 0;
    @(negedge clk);
    if (MemWrite) mw_seen++;
    if (resp_valid) rv_seen++;
    reset = 1'b0;
    check("rstmid.ready", 32'(req_ready), 32'd1);
    check("rstmid.a",     32'(a),         32'd0);
    repeat (4) begin
      @(negedge clk);
      if (MemWrite) mw_seen++;
      if (resp_valid) rv_seen++;
    end
    check("rstmid.no_memwrite", 32'(mw_seen), 32'd0);
    check("rstmid.no_resp",     32'(rv_seen), 32'd0);
    check("rstmid.word3",       mem[3],       32'hBEEFAB78);
    run_vec(vecs[19]);

    check("never_rd_and_wr", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the EX/MEM pipeline register and the word-wide Datamemory block.
- Converts byte, halfword and word requests at byte addresses into word accesses on Datamemory's MemRead/MemWrite/a/wd/rd interface.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Stalls the pipeline through req_ready while an access is in progress.

Parameters:
- DM_ADDRESS, 9, word-address width of Datamemory (2**DM_ADDRESS words).
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  request accepted when high with req_valid; low means stall.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- misaligned  out  1  valid with resp_valid; set on misaligned or illegal-size requests.
- MemRead  out  1  to Datamemory.
- MemWrite  out  1  to Datamemory.
- a  out  DM_ADDRESS  word address to Datamemory.
- wd  out  DATA_W  write data to Datamemory.
- rd  in  DATA_W  Datamemory read data; combinational, valid in the same cycle as MemRead/a.

Behaviour:
- Datamemory contract: writes commit on the rising edge while MemWrite=1.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; misaligned=0; MemRead=0; MemWrite=0; a=0; wd=0.
- Internal latches are cleared on reset.
- States: IDLE, RD, RMW_RD, WR, RESP.
- MemRead, MemWrite and a are decoded from the registered state and latched request only.
- req_ready=1 only in IDLE.
- IDLE, on req_valid, latches addr/size/we/unsigned/wdata, then branches:
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with misaligned=1. No memory access.
  - Load -> RD.
  - Word store -> WR, buffer=wdata.
  - Byte/half store -> RMW_RD.
- RD: MemRead=1, a=addr[DM_ADDRESS+1:2].
  - Select lane by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Sign- or zero-extend into resp buffer -> RESP.
- RMW_RD: MemRead=1.
  - buffer = rd with the target byte/half lane replaced by wdata[7:0] / wdata[15:0] -> WR.
- WR: MemWrite=1, wd=buffer, a=word address -> RESP.
- RESP: resp_valid=1 for exactly one cycle.
  - resp_rdata = load result, or 0 for stores and errors.
  - misaligned as latched.
  - Always returns to IDLE; the next request can be accepted in the following cycle.
- Latency from acceptance edge T to resp_valid:
  - load: T+2.
  - word store: T+2.
  - sub-word store: T+3.
  - error: T+1.
- MemRead and MemWrite are never high in the same cycle; at most one memory operation per state.
- Address bits above DM_ADDRESS+1 are ignored, so addresses wrap modulo memory size.
- req_* inputs are ignored outside IDLE; the upstream stage holds its request while req_ready=0.
- Reset in any state: next cycle is IDLE with all outputs at reset values.
  - An in-flight request is dropped with no resp_valid.
  - A store reset in RMW_RD never asserts MemWrite.
  - A store reset during WR may or may not commit, depending on the edge.
- resp_valid/misaligned/resp_rdata are registered; there is no combinational path from req_* to outputs.

Test Plan:
- Preload word 5=0x00700093; LB addr 20 (signed) -> MemRead one cycle, a=5; resp_valid at T+2, resp_rdata=0xFFFFFF93.
- LBU addr 20 -> 0x00000093. LH addr 22 -> 0x00000070. LW addr 20 -> 0x00700093. req_ready low for 2 cycles per request.
- SW addr 12 data 0x12345678 -> MemWrite one cycle, a=3, wd=0x12345678, no MemRead. Then SB addr 13 data 0x000000AB -> MemRead then MemWrite, wd=0x1234AB78. Then SH addr 14 data 0xBEEF -> word 3 becomes 0xBEEFAB78.
- LW addr 6, SH addr 9, and size=11 -> resp_valid at T+1 with misaligned=1 and resp_rdata=0; MemRead/MemWrite never asserted.
- Back-to-back requests with req_valid held high -> each accepted only in IDLE; no request lost or duplicated; addr 2068 (bit 11 set) maps to a=5.
- SB addr 13 data 0xCD with reset asserted during RMW_RD -> no MemWrite, no resp_valid, word 3 unchanged; the next request after reset completes normally.
